clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
Time-setting front end for the digital clock. It debounces three push-buttons (MODE, INC, DEC) and runs a set-mode FSM that steps through the hour, minute and second fields. It drives the LOAD/Data inputs of the three downstream mod-N field counters and gates their count enable. While not setting, it passes RUN_EN high so the counter chain free-runs.

Parameters:
W, 6, width of each field value and of DATA
MOD_H, 24, modulus of hour field
MOD_M, 60, modulus of minute field
MOD_S, 60, modulus of second field
DB_CYCLES, 4, consecutive stable synchronised samples required to accept a button level change

Ports:
Clk  in  1  system clock, rising edge
RST  in  1  asynchronous active-low reset
BTN_MODE  in  1  raw button, asynchronous, active-high
BTN_INC  in  1  raw button, asynchronous, active-high
BTN_DEC  in  1  raw button, asynchronous, active-high
CNT_H  in  W  current hour counter value
CNT_M  in  W  current minute counter value
CNT_S  in  W  current second counter value
RUN_EN  out  1  count enable to the field counters; low in any set state
LOAD  out  3  one-hot single-cycle load strobe; [2]=hour, [1]=minute, [0]=second
DATA  out  W  value to load; valid in every cycle where LOAD is non-zero
SEL  out  2  field being edited: 0=none, 1=hour, 2=minute, 3=second
SET_MODE  out  1  high in any set state

Behaviour:
- Reset (RST=0, asynchronous): state RUN; RUN_EN=1, LOAD=0, DATA=0, SEL=0, SET_MODE=0. Debounced levels clear to 0, debounce counters clear to 0, and synchronisers clear to 0. Reset asserted mid-edit aborts the edit immediately, and no LOAD is issued.
- Debounce, per button: 2-FF synchroniser, then a stable counter.
  - The debounced level changes only after the synchronised value has differed from it for DB_CYCLES consecutive cycles.
  - Any cycle where the two agree clears the counter.
  - A press is a single-cycle pulse on the rising edge of the debounced level. Releases generate nothing.
  - Latency: a raw rising edge first sampled at edge k produces the press pulse high in cycle k+2+DB_CYCLES.
- FSM states: RUN, SET_H, SET_M, SET_S.
  - A MODE press advances RUN -> SET_H -> SET_M -> SET_S -> RUN.
  - On entry to SET_x, the edit register is loaded with CNT_x, sampled in the cycle the MODE press is seen.
- Outputs per state: SEL = 0/1/2/3 and SET_MODE = 0/1/1/1. RUN_EN = 1 only in RUN. These are registered outputs that change the cycle after the MODE press.
- INC press in SET_x: edit = (edit == MOD_x-1) ? 0 : edit+1.
- DEC press in SET_x: edit = (edit == 0) ? MOD_x-1 : edit-1.
- After an INC or DEC update, the next cycle has LOAD one-hot for field x for exactly 1 cycle, with DATA equal to the new edit value. DATA holds its last value afterwards.
- INC or DEC presses in RUN are ignored.
- Simultaneous events:
  - MODE together with INC/DEC in the same cycle: MODE wins and INC/DEC are dropped.
  - INC and DEC in the same cycle: both are dropped.
- Edit values are always in 0..MOD_x-1. CNT_x values at or above MOD_x on entry are clamped to 0.
- The exit SET_S -> RUN issues no LOAD. RUN_EN rises the cycle after the MODE press.

Decomposition:
- Shared package (clock_pkg) holds:
  - state encoding constants ST_RUN=2'd0, ST_SET_H=2'd1, ST_SET_M=2'd2, ST_SET_S=2'd3;
  - the SEL encodings and LOAD bit indices;
  - the default moduli 24/60/60.
- One sub-module, btn_debounce (synchroniser, stable counter, press pulse; parameter DB_CYCLES), instantiated three times.
- The FSM and edit datapath stay in clock_set_ctrl.

Test Plan:
- Reset, then RST=1 with no buttons for 50 cycles -> RUN_EN=1, LOAD=0, SEL=0, SET_MODE=0 throughout.
- BTN_MODE glitch high for 2 cycles (< DB_CYCLES) -> no state change. Then hold high 10 cycles -> press pulse exactly at k+6; SEL=1 and RUN_EN=0 the cycle after.
- In SET_H with CNT_H=23, one INC press -> LOAD=3'b100 for 1 cycle with DATA=0. Then one DEC press -> LOAD=3'b100 with DATA=23.
- Advance to SET_M with CNT_M=0 and DEC press -> DATA=59, LOAD=3'b010. In SET_S, INC and DEC pressed the same cycle -> no LOAD.
- In SET_S, MODE and INC pressed the same cycle -> state RUN, no LOAD, RUN_EN=1 the next cycle.
- In SET_M, an INC press followed by RST pulled low 1 cycle later -> all outputs at reset values immediately; state RUN after release; no further LOAD.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: shared state encoding, field selects, load indices and default moduli.
package clock_pkg;
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2,
    ST_SET_S = 2'd3
  } state_t;
  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_H = 2'd1;
  localparam logic [1:0] SEL_M = 2'd2;
  localparam logic [1:0] SEL_S = 2'd3;
  localparam int LD_H = 2;
  localparam int LD_M = 1;
  localparam int LD_S = 0;
  localparam int MOD_H_DEF = 24;
  localparam int MOD_M_DEF = 60;
  localparam int MOD_S_DEF = 60;
  function automatic logic [1:0] sel_of(state_t s);
    return s == ST_SET_H ? SEL_H : s == ST_SET_M ? SEL_M : s == ST_SET_S ? SEL_S : SEL_NONE;
  endfunction
  function automatic logic [2:0] ld_of(state_t s);
    return s == ST_SET_H ? 3'(1 << LD_H) : s == ST_SET_M ? 3'(1 << LD_M) :
           s == ST_SET_S ? 3'(1 << LD_S) : 3'b000;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stable-count debounce and registered press pulse.
module btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic level, level_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync    <= {sync[0], btn};
      level_d <= level;
      press   <= level & ~level_d;
      // any agreeing cycle restarts the stability window
      if (sync[1] != level) begin
        if (cnt == CW'(DB_CYCLES - 1)) begin
          level <= sync[1];
          cnt   <= '0;
        end else cnt <= cnt + CW'(1);
      end else cnt <= '0;
    end
  end
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven set-mode FSM that edits hour/minute/second fields
// and drives the field counters' load strobes and run enable.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int W         = 6,
  parameter int MOD_H     = MOD_H_DEF,
  parameter int MOD_M     = MOD_M_DEF,
  parameter int MOD_S     = MOD_S_DEF,
  parameter int DB_CYCLES = 4
) (
  input  logic         Clk,
  input  logic         RST,
  input  logic         BTN_MODE,
  input  logic         BTN_INC,
  input  logic         BTN_DEC,
  input  logic [W-1:0] CNT_H,
  input  logic [W-1:0] CNT_M,
  input  logic [W-1:0] CNT_S,
  output logic         RUN_EN,
  output logic [2:0]   LOAD,
  output logic [W-1:0] DATA,
  output logic [1:0]   SEL,
  output logic         SET_MODE
);
  logic p_mode, p_inc, p_dec;
  state_t state, state_nx;
  logic [W-1:0] edit, edit_nx, max_cur, max_nx, cnt_nx;
  logic [2:0] load_nx;
  logic step_up, step_dn;
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_mode (.clk(Clk), .rst_n(RST), .btn(BTN_MODE), .press(p_mode));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_inc  (.clk(Clk), .rst_n(RST), .btn(BTN_INC),  .press(p_inc));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_dec  (.clk(Clk), .rst_n(RST), .btn(BTN_DEC),  .press(p_dec));
  always_comb begin
    state_nx = p_mode ? state_t'(state + 2'd1) : state;
    max_cur  = state == ST_SET_H ? W'(MOD_H - 1) : state == ST_SET_M ? W'(MOD_M - 1) : W'(MOD_S - 1);
    max_nx   = state_nx == ST_SET_H ? W'(MOD_H - 1) : state_nx == ST_SET_M ? W'(MOD_M - 1) : W'(MOD_S - 1);
    cnt_nx   = state_nx == ST_SET_H ? CNT_H : state_nx == ST_SET_M ? CNT_M : CNT_S;
    // MODE dominates; INC and DEC together cancel
    step_up  = !p_mode && p_inc && !p_dec && state != ST_RUN;
    step_dn  = !p_mode && p_dec && !p_inc && state != ST_RUN;
    edit_nx  = (p_mode && state_nx != ST_RUN) ? (cnt_nx > max_nx ? '0 : cnt_nx) :
               step_up ? (edit == max_cur ? '0 : edit + W'(1)) :
               step_dn ? (edit == '0 ? max_cur : edit - W'(1)) : edit;
    load_nx  = (step_up || step_dn) ? ld_of(state) : 3'b000;
  end
  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      state    <= ST_RUN;
      edit     <= '0;
      LOAD     <= '0;
      DATA     <= '0;
      SEL      <= SEL_NONE;
      RUN_EN   <= 1'b1;
      SET_MODE <= 1'b0;
    end else begin
      state    <= state_nx;
      edit     <= edit_nx;
      LOAD     <= load_nx;
      SEL      <= sel_of(state_nx);
      RUN_EN   <= state_nx == ST_RUN;
      SET_MODE <= state_nx != ST_RUN;
      if (|load_nx) DATA <= edit_nx;
    end
  end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: randomized scoreboard bench with a field-level reference model.
module tb_clock_set_ctrl;
  logic Clk = 1'b0;
  logic RST = 1'b0;
  logic BTN_MODE = 1'b0, BTN_INC = 1'b0, BTN_DEC = 1'b0;
  logic [5:0] CNT_H = '0, CNT_M = '0, CNT_S = '0;
  logic RUN_EN, SET_MODE;
  logic [2:0] LOAD;
  logic [5:0] DATA;
  logic [1:0] SEL;
  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];
  int s = 0;
  int e = 0;

  clock_set_ctrl dut (
    .Clk(Clk), .RST(RST), .BTN_MODE(BTN_MODE), .BTN_INC(BTN_INC), .BTN_DEC(BTN_DEC),
    .CNT_H(CNT_H), .CNT_M(CNT_M), .CNT_S(CNT_S), .RUN_EN(RUN_EN), .LOAD(LOAD),
    .DATA(DATA), .SEL(SEL), .SET_MODE(SET_MODE)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic int mod_of(input int f);
    return f == 1 ? 24 : 60;
  endfunction

  function automatic int cnt_of(input int f);
    return f == 1 ? int'(CNT_H) : f == 2 ? int'(CNT_M) : int'(CNT_S);
  endfunction

  task automatic chk_state(input string name);
    chk({name, "_sel"}, 32'(SEL), 32'(s));
    chk({name, "_run"}, 32'({RUN_EN, SET_MODE}), s == 0 ? 32'b10 : 32'b01);
  endtask

  task automatic op(input bit m, input bit i, input bit d);
    if (m) begin
      s = (s + 1) % 4;
      if (s != 0) e = cnt_of(s) >= mod_of(s) ? 0 : cnt_of(s);
    end else if ((i ^ d) && s != 0) begin
      e = i ? (e + 1) % mod_of(s) : (e + mod_of(s) - 1) % mod_of(s);
      exp_q.push_back({3'b100 >> (s - 1), 6'(e)});
    end
    BTN_MODE = m; BTN_INC = i; BTN_DEC = d;
    repeat (8) tick();
    BTN_MODE = 0; BTN_INC = 0; BTN_DEC = 0;
    repeat (12) tick();
  endtask

  always @(negedge Clk) begin
    if (RST && LOAD != 3'b000) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_load got LOAD=%b DATA=%0d want no load", LOAD, DATA);
      end else begin
        logic [8:0] x;
        x = exp_q.pop_front();
        if ({LOAD, DATA} !== x) begin
          failures++;
          $display("FAIL load_data got LOAD=%b DATA=%0d want LOAD=%b DATA=%0d", LOAD, DATA, x[8:6], x[5:0]);
        end
      end
    end
  end

  initial begin
    int n;
    int r;
    repeat (3) tick();
    chk("reset_outs", 32'({RUN_EN, LOAD, DATA, SEL, SET_MODE}), 32'({1'b1, 3'b0, 6'd0, 2'd0, 1'b0}));
    RST = 1;
    for (int k = 0; k < 50; k++) begin
      tick();
      chk("idle", 32'({RUN_EN, LOAD, SEL, SET_MODE}), 32'({1'b1, 3'b0, 2'd0, 1'b0}));
    end
    BTN_MODE = 1;
    repeat (2) tick();
    BTN_MODE = 0;
    repeat (12) tick();
    chk_state("glitch");
    CNT_H = 23;
    BTN_MODE = 1;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (n == 0 && SEL != 2'd0) n = k;
      if (k == 10) BTN_MODE = 0;
    end
    chk("mode_latency", 32'(n), 32'd8);
    s = 1;
    e = 23;
    chk_state("enter_h");
    op(0, 1, 0);
    op(0, 0, 1);
    CNT_M = 0;
    op(1, 0, 0);
    chk_state("enter_m");
    op(0, 0, 1);
    CNT_S = 6'd61;
    op(1, 0, 0);
    chk_state("enter_s");
    op(0, 1, 1);
    op(1, 1, 0);
    chk_state("exit_run");
    op(0, 1, 0);
    op(1, 0, 0);
    op(1, 0, 0);
    chk_state("reenter_m");
    BTN_INC = 1;
    repeat (7) tick();
    RST = 0;
    #1;
    chk("abort_reset", 32'({RUN_EN, LOAD, DATA, SEL, SET_MODE}), 32'({1'b1, 3'b0, 6'd0, 2'd0, 1'b0}));
    BTN_INC = 0;
    repeat (2) tick();
    RST = 1;
    s = 0;
    repeat (20) tick();
    chk_state("after_abort");
    for (int k = 0; k < 60; k++) begin
      CNT_H = 6'($urandom_range(0, 63));
      CNT_M = 6'($urandom_range(0, 63));
      CNT_S = 6'($urandom_range(0, 63));
      r = $urandom_range(0, 9);
      if (r < 3) op(1, 0, 0);
      else if (r < 6) op(0, 1, 0);
      else if (r < 8) op(0, 0, 1);
      else if (r == 8) op(0, 1, 1);
      else op(1, r[0], ~r[0]);
      chk_state("rand");
    end
    repeat (10) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
